mslope_runup_ctrl: RTL and testbench
====================================

Name: mslope_runup_ctrl

Overview:
- Conversion sequencer for the multi-slope integrator.
- Per conversion it runs an optional auto-zero phase, then NCYCLES run-up periods. Each period's PWM pattern (mode A balanced / mode B wide) is chosen from the synchronised comparator.
- Then runs a single-slope run-down, timed in clocks, and reports the mode counts and run-down count with a done pulse.
- Sits between the conversion request logic and the integrator switch drivers.

Parameters:
- PERIOD, 259, clocks per run-up period (count 0..PERIOD-1); must be >= 8.
- NCYCLES, 1000, run-up periods per conversion.
- CNT_W, 32, width of n_a/n_b.
- RD_MAX, 1023, run-down timeout in clocks; rd_count width 10.
- SETTLE, 64, auto-zero length in clocks (AUTOZERO_EN only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin conversion; sampled only in IDLE
- abort  in  1  cancel conversion; return to IDLE
- comp  in  1  integrator comparator, asynchronous; 1 = integrator positive
- busy  out  1  high in any state except IDLE
- int_en  out  1  input switch closed (RUNUP only)
- pwm  out  1  reference switch during run-up
- rd_pos  out  1  positive run-down reference
- rd_neg  out  1  negative run-down reference
- az  out  1  auto-zero switch
- n_a  out  CNT_W  mode-A periods this conversion
- n_b  out  CNT_W  mode-B periods this conversion
- rd_count  out  10  run-down clocks
- rd_pol  out  1  comparator sign at run-down entry
- ov  out  1  run-down timeout occurred
- done  out  1  one-cycle result-valid pulse

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0. Reset mid-conversion aborts immediately; no done pulse.
- comp passes through a 2-flop synchroniser (comp_s). All decisions use comp_s.
- States: IDLE -> AZ (macro only) -> RUNUP -> RUNDOWN -> DONE -> IDLE.
- IDLE:
  - start=1 at an edge clears n_a, n_b, rd_count, ov.
  - Next cycle enters AZ, or RUNUP without the macro.
  - start while busy is ignored.
- RUNUP:
  - int_en=1. Period counter pc runs 0..PERIOD-1 and wraps.
  - Mode for period 0 = comp_s at entry. Mode for period k+1 = comp_s sampled at pc==PERIOD-1 of period k.
  - Mode A (comp_s=0): pwm=1 for (PERIOD>>1)-2 <= pc < (PERIOD>>1)+2, i.e. 4 clocks.
  - Mode B (comp_s=1): pwm=1 for 2 <= pc < PERIOD-2.
  - At pc==PERIOD-1, increment n_a or n_b per the current mode.
  - After the NCYCLES-th increment, go to RUNDOWN. pwm=0 and int_en=0 in that same next cycle.
- RUNDOWN:
  - On entry, latch rd_pol=comp_s.
  - rd_neg=1 if rd_pol=1, else rd_pos=1.
  - rd_count increments each cycle the drive is active.
  - Exit to DONE the first cycle comp_s != rd_pol, or when rd_count==RD_MAX (then ov=1, rd_count holds RD_MAX).
  - Drives drop to 0 on exit.
- DONE: done=1 for one cycle, then IDLE. n_a, n_b, rd_count, rd_pol and ov hold until the next accepted start.
- abort=1 in any busy state: next cycle IDLE, all switch outputs 0, no done, result regs keep partial values.
- Simultaneous events:
  - abort and start together in IDLE: abort wins; start is ignored.
  - rst dominates everything.
- Invariant: n_a+n_b==NCYCLES at done. No counter overflow is possible (NCYCLES < 2^CNT_W, checked by an assertion).
- Only one of pwm/rd_pos/rd_neg/az is high in any cycle.

Optional Feature:
- MSLOPE_AUTOZERO_EN defined:
  - AZ state holds az=1 for exactly SETTLE clocks; int_en, pwm and rd drives are 0.
  - Then RUNUP. abort is honoured in AZ.
- Not defined: AZ state is absent, the az port is tied 0, and start enters RUNUP directly.

Decomposition:
- Shared package mslope_pkg:
  - state encoding enum (IDLE, AZ, RUNUP, RUNDOWN, DONE)
  - mode constants MODE_A=0, MODE_B=1
  - default PERIOD, and helper functions for the mode start/finish windows
- One sub-module, mslope_period_gen: owns pc, the wrap strobe and the pwm window compare given mode. The controller owns the FSM and counters.

Test Plan:
- PERIOD=259, NCYCLES=4, comp=0 throughout:
  - pwm high for pc 127..130 each period; n_a=4, n_b=0.
  - Run-down drives rd_pos, rd_pol=0.
  - comp rises 20 clocks into run-down -> rd_count=20+sync latency, then done pulse.
- comp=1 throughout run-up: pwm high for pc 2..256 (255 clocks) per period; n_b=4, n_a=0.
- comp toggled each period boundary: modes alternate with 1-period lag; n_a+n_b=4.
- Run-down with comp never flipping: rd_count=1023, ov=1, done pulses.
- abort mid-RUNUP period 2: IDLE next cycle, pwm=0, int_en=0, no done. rst asserted mid-RUNDOWN: all outputs 0 asynchronously.
- Macro on, SETTLE=64: az high exactly 64 clocks before int_en rises. Macro off: int_en rises the cycle after start.

Source files
------------

// File: rtl/mslope_pkg.sv
// Shared definitions for the multi-slope run-up controller: state codes,
// PWM mode enum and the run-up window helpers.
package mslope_pkg;

    localparam int PERIOD_DEF = 259;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_AZ      = 3'd1;
    localparam logic [2:0] ST_RUNUP   = 3'd2;
    localparam logic [2:0] ST_RUNDOWN = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    typedef enum logic {
        MODE_A = 1'b0,
        MODE_B = 1'b1
    } mode_e;

    // Mode A pulses a short balanced window around the period midpoint;
    // mode B holds the reference for all but two clocks at each end.
    function automatic int win_start(input mode_e mode, input int period);
        if (mode == MODE_B) return 2;
        return (period >> 1) - 2;
    endfunction

    function automatic int win_finish(input mode_e mode, input int period);
        if (mode == MODE_B) return period - 2;
        return (period >> 1) + 2;
    endfunction

endpackage

// File: rtl/mslope_period_gen.sv
// Run-up period counter: owns pc, the end-of-period wrap strobe and the
// PWM window compare for the mode chosen by the controller.
module mslope_period_gen
    import mslope_pkg::*;
#(
    parameter int PERIOD = PERIOD_DEF
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  run,
    input  mode_e mode,
    output logic  wrap,
    output logic  pwm
);

    localparam int              PC_W    = $clog2(PERIOD);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PERIOD - 1);
    localparam logic [PC_W-1:0] A_LO    = PC_W'(win_start(MODE_A, PERIOD));
    localparam logic [PC_W-1:0] A_HI    = PC_W'(win_finish(MODE_A, PERIOD));
    localparam logic [PC_W-1:0] B_LO    = PC_W'(win_start(MODE_B, PERIOD));
    localparam logic [PC_W-1:0] B_HI    = PC_W'(win_finish(MODE_B, PERIOD));

    logic [PC_W-1:0] pc_q, pc_d;
    logic            in_a, in_b;

    // pc sits at 0 outside run-up so every conversion starts on a clean period.
    always_comb begin
        wrap = run && (pc_q == PC_LAST);
        pc_d = '0;
        if (run && !wrap) begin
            pc_d = pc_q + PC_W'(1);
        end
        in_a = (pc_q >= A_LO) && (pc_q < A_HI);
        in_b = (pc_q >= B_LO) && (pc_q < B_HI);
        pwm  = run && ((mode == MODE_B) ? in_b : in_a);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/mslope_runup_ctrl.sv
// Multi-slope conversion sequencer: optional auto-zero, NCYCLES run-up
// periods, timed run-down. Auto-zero is built only with MSLOPE_AUTOZERO_EN.
module mslope_runup_ctrl
    import mslope_pkg::*;
#(
    parameter int PERIOD  = PERIOD_DEF,
    parameter int NCYCLES = 1000,
    parameter int CNT_W   = 32,
    parameter int RD_MAX  = 1023,
    parameter int SETTLE  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             comp,
    output logic             busy,
    output logic             int_en,
    output logic             pwm,
    output logic             rd_pos,
    output logic             rd_neg,
    output logic             az,
    output logic [CNT_W-1:0] n_a,
    output logic [CNT_W-1:0] n_b,
    output logic [9:0]       rd_count,
    output logic             rd_pol,
    output logic             ov,
    output logic             done,
    output logic [2:0]       dbg_state
);

    localparam int               CYC_W    = $clog2(NCYCLES + 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(NCYCLES - 1);
    localparam logic [9:0]       RD_LAST  = 10'(RD_MAX - 1);

    logic             comp_meta_q, comp_s_q;
    logic [2:0]       state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] n_a_q, n_a_d, n_b_q, n_b_d;
    logic [9:0]       rd_count_q, rd_count_d;
    logic             rd_pol_q, rd_pol_d;
    logic             ov_q, ov_d;
    logic             wrap;
`ifdef MSLOPE_AUTOZERO_EN
    localparam int              AZ_W    = $clog2(SETTLE + 1);
    localparam logic [AZ_W-1:0] AZ_LAST = AZ_W'(SETTLE - 1);
    logic [AZ_W-1:0]            az_cnt_q, az_cnt_d;
`endif

    // Handshake: start is accepted only in IDLE with abort low; done is a
    // one-cycle strobe without back-pressure, and n_a/n_b/rd_count/rd_pol/ov
    // stay valid from done until the next accepted start.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cyc_d      = cyc_q;
        n_a_d      = n_a_q;
        n_b_d      = n_b_q;
        rd_count_d = rd_count_q;
        rd_pol_d   = rd_pol_q;
        ov_d       = ov_q;
`ifdef MSLOPE_AUTOZERO_EN
        az_cnt_d   = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    n_a_d      = '0;
                    n_b_d      = '0;
                    rd_count_d = '0;
                    ov_d       = 1'b0;
                    cyc_d      = '0;
                    mode_d     = mode_e'(comp_s_q);
`ifdef MSLOPE_AUTOZERO_EN
                    state_d    = ST_AZ;
`else
                    state_d    = ST_RUNUP;
`endif
                end
            end
`ifdef MSLOPE_AUTOZERO_EN
            ST_AZ: begin
                if (az_cnt_q == AZ_LAST) begin
                    state_d = ST_RUNUP;
                    mode_d  = mode_e'(comp_s_q);
                end else begin
                    az_cnt_d = az_cnt_q + AZ_W'(1);
                end
            end
`endif
            ST_RUNUP: begin
                if (wrap) begin
                    if (mode_q == MODE_B) n_b_d = n_b_q + CNT_W'(1);
                    else                  n_a_d = n_a_q + CNT_W'(1);
                    // Comparator at the last clock of a period picks the next period's mode.
                    mode_d = mode_e'(comp_s_q);
                    cyc_d  = cyc_q + CYC_W'(1);
                    if (cyc_q == CYC_LAST) begin
                        state_d  = ST_RUNDOWN;
                        rd_pol_d = comp_s_q;
                    end
                end
            end
            ST_RUNDOWN: begin
                rd_count_d = rd_count_q + 10'd1;
                if (comp_s_q != rd_pol_q) begin
                    state_d = ST_DONE;
                end else if (rd_count_q == RD_LAST) begin
                    state_d = ST_DONE;
                    ov_d    = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            comp_meta_q <= 1'b0;
            comp_s_q    <= 1'b0;
            state_q     <= ST_IDLE;
            mode_q      <= MODE_A;
            cyc_q       <= '0;
            n_a_q       <= '0;
            n_b_q       <= '0;
            rd_count_q  <= '0;
            rd_pol_q    <= 1'b0;
            ov_q        <= 1'b0;
`ifdef MSLOPE_AUTOZERO_EN
            az_cnt_q    <= '0;
`endif
        end else begin
            comp_meta_q <= comp;
            comp_s_q    <= comp_meta_q;
            state_q     <= state_d;
            mode_q      <= mode_d;
            cyc_q       <= cyc_d;
            n_a_q       <= n_a_d;
            n_b_q       <= n_b_d;
            rd_count_q  <= rd_count_d;
            rd_pol_q    <= rd_pol_d;
            ov_q        <= ov_d;
`ifdef MSLOPE_AUTOZERO_EN
            az_cnt_q    <= az_cnt_d;
`endif
        end
    end

    mslope_period_gen #(
        .PERIOD (PERIOD)
    ) u_period_gen (
        .clk  (clk),
        .rst  (rst),
        .run  (state_q == ST_RUNUP),
        .mode (mode_q),
        .wrap (wrap),
        .pwm  (pwm)
    );

    assign busy      = (state_q != ST_IDLE);
    assign int_en    = (state_q == ST_RUNUP);
    assign rd_pos    = (state_q == ST_RUNDOWN) && !rd_pol_q;
    assign rd_neg    = (state_q == ST_RUNDOWN) && rd_pol_q;
    assign done      = (state_q == ST_DONE);
    assign n_a       = n_a_q;
    assign n_b       = n_b_q;
    assign rd_count  = rd_count_q;
    assign rd_pol    = rd_pol_q;
    assign ov        = ov_q;
    assign dbg_state = state_q;
`ifdef MSLOPE_AUTOZERO_EN
    assign az        = (state_q == ST_AZ);
`else
    assign az        = 1'b0;
`endif

    param_ok: assert property (@(posedge clk)
        (PERIOD >= 8) && (SETTLE >= 1) && (64'(NCYCLES) < (64'd1 << CNT_W)));
    sum_ok: assert property (@(posedge clk) disable iff (rst)
        done |-> (({1'b0, n_a_q} + {1'b0, n_b_q}) == (CNT_W + 1)'(NCYCLES)));
    drive_excl: assert property (@(posedge clk) disable iff (rst)
        $onehot0({pwm, rd_pos, rd_neg, az}));

endmodule

// File: tb/tb_mslope_runup_ctrl.sv
// Directed bench for mslope_runup_ctrl (PERIOD=259, NCYCLES=4); builds with
// or without MSLOPE_AUTOZERO_EN.
module tb_mslope_runup_ctrl;

    localparam int PERIOD  = 259;
    localparam int NCYC    = 4;
    localparam int CNT_W   = 32;
    localparam int RD_MAX  = 1023;
    localparam int SETTLE  = 64;

    logic             clk, rst, start, abort, comp;
    logic             busy, int_en, pwm, rd_pos, rd_neg, az, rd_pol, ov, done;
    logic [CNT_W-1:0] n_a, n_b;
    logic [9:0]       rd_count;
    logic [2:0]       dbg_state;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic comp_init;
        logic toggle;
        int   flip_at;
        int   exp_na;
        int   exp_nb;
        int   exp_rd;
        logic exp_pol;
        logic exp_ov;
    } vec_t;

    vec_t vecs[5];

    mslope_runup_ctrl #(
        .PERIOD (PERIOD),
        .NCYCLES(NCYC),
        .CNT_W  (CNT_W),
        .RD_MAX (RD_MAX),
        .SETTLE (SETTLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .comp     (comp),
        .busy     (busy),
        .int_en   (int_en),
        .pwm      (pwm),
        .rd_pos   (rd_pos),
        .rd_neg   (rd_neg),
        .az       (az),
        .n_a      (n_a),
        .n_b      (n_b),
        .rd_count (rd_count),
        .rd_pol   (rd_pol),
        .ov       (ov),
        .done     (done),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] flags();
        return {55'd0, busy, int_en, pwm, rd_pos, rd_neg, az, done, ov, rd_pol};
    endfunction

    function automatic logic [63:0] results();
        return {n_a[15:0], n_b[15:0], 6'd0, rd_count, 14'd0, rd_pol, ov};
    endfunction

    // Start a conversion and wait for the first run-up cycle (pc=0).
    task automatic begin_conv();
        int az_n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef MSLOPE_AUTOZERO_EN
        az_n = 0;
        for (int i = 0; i < SETTLE + 8 && !int_en; i++) begin
            if (az) az_n++;
            @(negedge clk);
        end
        check("az_len", az_n, SETTLE);
        check("int_en_after_az", int_en, 1);
`else
        check("int_en_rise", int_en, 1);
`endif
    endtask

    task automatic run_conv(input int idx, input vec_t v);
        logic modes[NCYC + 1];
        logic cur_comp;
        int   hi, first, last, bad, drv, n;
        int   e_cnt, e_first, e_last;
        comp = v.comp_init;
        cur_comp = v.comp_init;
        repeat (4) @(negedge clk);
        begin_conv();
        modes[0] = v.comp_init;
        for (int p = 0; p < NCYC; p++) begin
            hi = 0; first = -1; last = -1; bad = 0;
            for (int pc = 0; pc < PERIOD; pc++) begin
                if (pwm) begin
                    hi++;
                    if (first < 0) first = pc;
                    last = pc;
                end
                if (!int_en || !busy || rd_pos || rd_neg || az || done) bad++;
                if (v.toggle && pc == 0) begin
                    cur_comp = p[0];
                    comp = cur_comp;
                end
                // A start while busy must not restart the conversion.
                start = (p == 1 && pc == 100);
                @(negedge clk);
            end
            modes[p + 1] = cur_comp;
            if (modes[p]) begin
                e_cnt = PERIOD - 4; e_first = 2; e_last = PERIOD - 3;
            end else begin
                e_cnt = 4; e_first = PERIOD / 2 - 2; e_last = PERIOD / 2 + 1;
            end
            check($sformatf("v%0d_pwm_win_p%0d", idx, p),
                  {16'd0, 16'(hi), 16'(first), 16'(last)},
                  {16'd0, 16'(e_cnt), 16'(e_first), 16'(e_last)});
            check($sformatf("v%0d_runup_flags_p%0d", idx, p), bad, 0);
        end
        drv = 0; bad = 0; n = 0;
        while (!done && n < RD_MAX + 8) begin
            if (rd_pos || rd_neg) drv++;
            if (rd_pos !== !v.exp_pol || rd_neg !== v.exp_pol || int_en || pwm || az) bad++;
            if (v.flip_at == n) comp = ~comp;
            n++;
            @(negedge clk);
        end
        check($sformatf("v%0d_done_seen", idx), done, 1);
        check($sformatf("v%0d_rd_drive_cycles", idx), drv, v.exp_rd);
        check($sformatf("v%0d_rd_drive_sign", idx), bad, 0);
        check($sformatf("v%0d_results", idx), results(),
              {16'(v.exp_na), 16'(v.exp_nb), 6'd0, 10'(v.exp_rd), 14'd0, v.exp_pol, v.exp_ov});
        check($sformatf("v%0d_done_flags", idx), flags(),
              {55'd0, 1'b1, 5'b00000, 1'b1, v.exp_ov, v.exp_pol});
        @(negedge clk);
        check($sformatf("v%0d_idle_after_done", idx), flags(),
              {55'd0, 1'b0, 5'b00000, 1'b0, v.exp_ov, v.exp_pol});
        check($sformatf("v%0d_results_hold", idx), results(),
              {16'(v.exp_na), 16'(v.exp_nb), 6'd0, 10'(v.exp_rd), 14'd0, v.exp_pol, v.exp_ov});
    endtask

    initial begin
        int dn;
        // comp_init, toggle, flip_at, n_a, n_b, rd_count, rd_pol, ov
        // A flip applied in run-down cycle k reaches comp_s two clocks later and
        // that exit cycle still drives, so rd_count = k + 3.
        vecs[0] = '{1'b0, 1'b0, 20, 4, 0, 23,     1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, -1, 0, 4, RD_MAX, 1'b1, 1'b1};
        // Toggle: period modes B,A,B,A (one-period lag); comp is 1 during the last period.
        vecs[2] = '{1'b1, 1'b1, 5,  2, 2, 8,      1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, -1, 4, 0, RD_MAX, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 0,  0, 4, 3,      1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; comp = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_flags", flags(), 64'd0);
        check("reset_results", results(), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_flags", flags(), 64'd0);

        for (int i = 0; i < 5; i++) begin
            run_conv(i, vecs[i]);
        end

        // abort together with start in IDLE: abort wins.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start_idle", busy, 0);
        @(negedge clk);
        check("abort_start_idle_later", busy, 0);

        // abort in the middle of run-up period 2 (comp low: two mode-A periods done).
        comp = 1'b0;
        repeat (4) @(negedge clk);
        begin_conv();
        repeat (2 * PERIOD + 50) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_runup_flags", {busy, int_en, pwm, done}, 4'b0000);
        check("abort_partial_counts", {n_a[15:0], n_b[15:0]}, {16'd2, 16'd0});
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy) dn++;
            @(negedge clk);
        end
        check("abort_no_done", dn, 0);

        // Asynchronous reset in the middle of run-down.
        begin_conv();
        for (int i = 0; i < 3000 && !rd_pos; i++) @(negedge clk);
        check("rundown_reached", rd_pos, 1);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_flags", flags(), 64'd0);
        check("async_rst_results", results(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_flags", flags(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
